// File: rtl/mod_alu_pipe.sv
// Two-stage pipelined modulo add/sub/inc/dec ALU for the clock/calendar fields.
// Latency 2 cycles from acceptance to out_valid; 1 op/cycle while out_ready=1.
// Backpressure: stage 1 fills its bubble while stage 2 stalls; in_ready drops once both are full.
module mod_alu_pipe #(
    parameter int WIDTH   = 6,
    parameter int MODULUS = 60,
    parameter int TAG_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    // Two guard bits hold -MODULUS..2*MODULUS-1 even when MODULUS = 2**WIDTH.
    localparam int RW = WIDTH + 2;
    localparam logic signed [RW-1:0] MOD_S = RW'(MODULUS);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_INC = 2'b10;

    typedef struct packed {
        logic signed [RW-1:0] raw;
        logic                 err;
        logic [TAG_W-1:0]     tag;
    } s1_t;

    logic                    s1_vld;
    s1_t                     s1_d;
    s1_t                     s1_q;
    logic                    s2_vld;
    logic                    s2_adv;
    logic [WIDTH-1:0]        s2_res_q;
    logic                    s2_cout_q;
    logic                    s2_err_q;
    logic [TAG_W-1:0]        s2_tag_q;
    logic [WIDTH-1:0]        s2_res_d;
    logic                    s2_cout_d;

    logic signed [RW-1:0]    a_x;
    logic signed [RW-1:0]    b_x;
    logic signed [RW-1:0]    c_x;
    logic signed [RW-1:0]    raw_q;

    assign s2_adv   = !s2_vld || out_ready;
    assign in_ready = !s1_vld || s2_adv;

    assign a_x = $signed({2'b00, in_a});
    assign b_x = $signed({2'b00, in_b});
    assign c_x = $signed({{(RW-1){1'b0}}, in_cin});

    always_comb begin
        s1_d     = '0;
        s1_d.tag = in_tag;
        case (in_op)
            OP_ADD:  s1_d.raw = a_x + b_x + c_x;
            OP_SUB:  s1_d.raw = a_x - b_x - c_x;
            OP_INC:  s1_d.raw = a_x + c_x;
            default: s1_d.raw = a_x - c_x;
        endcase
        // B only matters for the two-operand ops.
        s1_d.err = (a_x >= MOD_S) || ((b_x >= MOD_S) && !in_op[1]);
    end

    assign raw_q = s1_q.raw;

    always_comb begin
        s2_res_d  = '0;
        s2_cout_d = 1'b0;
        if (s1_q.err) begin
            s2_res_d  = '0;
            s2_cout_d = 1'b0;
        end else if (raw_q >= MOD_S) begin
            s2_res_d  = WIDTH'(raw_q - MOD_S);
            s2_cout_d = 1'b1;
        end else if (raw_q[RW-1]) begin
            s2_res_d  = WIDTH'(raw_q + MOD_S);
            s2_cout_d = 1'b1;
        end else begin
            s2_res_d  = WIDTH'(raw_q);
            s2_cout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_q      <= '0;
            s2_vld    <= 1'b0;
            s2_res_q  <= '0;
            s2_cout_q <= 1'b0;
            s2_err_q  <= 1'b0;
            s2_tag_q  <= '0;
        end else begin
            if (in_ready) begin
                s1_vld <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_adv) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_res_q  <= s2_res_d;
                    s2_cout_q <= s2_cout_d;
                    s2_err_q  <= s1_q.err;
                    s2_tag_q  <= s1_q.tag;
                end
            end
        end
    end

    assign out_valid  = s2_vld;
    assign out_result = s2_res_q;
    assign out_cout   = s2_cout_q;
    assign out_err    = s2_err_q;
    assign out_tag    = s2_tag_q;

endmodule

// File: tb/tb_mod_alu_pipe.sv
// Bench for mod_alu_pipe (WIDTH=6, MODULUS=60): vector table, stall/reset sequences, random stream.
module tb_mod_alu_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_a;
    logic [5:0] in_b;
    logic [1:0] in_op;
    logic       in_cin;
    logic [1:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_result;
    logic       out_cout;
    logic       out_err;
    logic [1:0] out_tag;

    mod_alu_pipe #(.WIDTH(6), .MODULUS(60), .TAG_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cout(out_cout), .out_err(out_err), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int res;
        int cout;
        int err;
        int tag;
    } exp_t;

    typedef struct {
        logic [1:0] op;
        int a;
        int b;
        logic cin;
        int res;
        int cout;
        int err;
    } vec_t;

    exp_t q[$];
    int   pop_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   done;
    vec_t vt[16];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input int a, input int b,
                                   input logic cin, input logic [1:0] tag);
        exp_t e;
        int raw;
        int c;
        c = cin ? 1 : 0;
        case (op)
            2'd0:    raw = a + b + c;
            2'd1:    raw = a - b - c;
            2'd2:    raw = a + c;
            default: raw = a - c;
        endcase
        e.tag = tag;
        e.err = ((a >= 60) || (b >= 60 && op < 2)) ? 1 : 0;
        if (e.err != 0) begin
            e.res = 0; e.cout = 0;
        end else if (raw >= 60) begin
            e.res = raw - 60; e.cout = 1;
        end else if (raw < 0) begin
            e.res = raw + 60; e.cout = 1;
        end else begin
            e.res = raw; e.cout = 0;
        end
        return e;
    endfunction

    // Scoreboard consumer: every handshaken result must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", out_result, e.res);
                chk("cout", out_cout, e.cout);
                chk("err", out_err, e.err);
                chk("tag", out_tag, e.tag);
            end
            pop_log.push_back(cyc);
        end
    end

    // Presents one op, waits for the transfer, records the expectation; leaves in_valid high.
    task automatic send(input logic [1:0] op, input int a, input int b, input logic cin,
                        input logic [1:0] tag, input int er, input int ec, input int ee);
        int n;
        exp_t e;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a[5:0];
        in_b     = b[5:0];
        in_cin   = cin;
        in_tag   = tag;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e.res = er; e.cout = ec; e.err = ee; e.tag = tag;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_in_time", (n < 200) ? 1 : 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{2'd1,  3,  5, 1'b1, 57, 1, 0};
        vt[1]  = '{2'd1, 10,  4, 1'b0,  6, 0, 0};
        vt[2]  = '{2'd2, 59,  0, 1'b1,  0, 1, 0};
        vt[3]  = '{2'd2, 58,  0, 1'b1, 59, 0, 0};
        vt[4]  = '{2'd3,  0,  0, 1'b1, 59, 1, 0};
        vt[5]  = '{2'd0, 60,  1, 1'b0,  0, 0, 1};
        vt[6]  = '{2'd0,  1,  2, 1'b0,  3, 0, 0};
        vt[7]  = '{2'd0, 59, 59, 1'b1, 59, 1, 0};
        vt[8]  = '{2'd1,  0, 59, 1'b1,  0, 1, 0};
        vt[9]  = '{2'd1,  5, 63, 1'b0,  0, 0, 1};
        vt[10] = '{2'd2,  5, 63, 1'b1,  6, 0, 0};
        vt[11] = '{2'd3, 62,  0, 1'b0,  0, 0, 1};
        vt[12] = '{2'd3,  7,  0, 1'b0,  7, 0, 0};
        vt[13] = '{2'd0, 30, 29, 1'b1,  0, 1, 0};
        vt[14] = '{2'd0, 30, 29, 1'b0, 59, 0, 0};
        vt[15] = '{2'd0,  0,  0, 1'b0,  0, 0, 0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        in_cin = 1'b0; in_tag = '0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_in_ready", in_ready, 1);

        // Latency: accepted op shows up exactly two cycles later.
        send(2'd0, 45, 20, 1'b0, 2'd3, 5, 1, 0);
        in_valid = 1'b0;
        chk("lat_cycle1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_cycle2_valid", out_valid, 1);
        chk("lat_cycle2_result", out_result, 5);
        wait_drain();

        // Table at full rate; results must come back without gaps.
        pop_log.delete();
        for (int i = 0; i < 16; i++) begin
            send(vt[i].op, vt[i].a, vt[i].b, vt[i].cin, 2'(i),
                 vt[i].res, vt[i].cout, vt[i].err);
        end
        in_valid = 1'b0;
        wait_drain();
        chk("table_count", pop_log.size(), 16);
        if (pop_log.size() == 16) chk("table_no_gaps", pop_log[15] - pop_log[0], 15);

        // Stall: two ops absorbed, in_ready drops, outputs frozen, then in-order burst.
        out_ready = 1'b0;
        send(2'd0, 1, 1, 1'b0, 2'd0, 2, 0, 0);
        send(2'd0, 1, 1, 1'b0, 2'd1, 2, 0, 0);
        in_tag = 2'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_tag", out_tag, 0);
            chk("stall_out_result", out_result, 2);
            @(posedge clk);
            #1;
        end
        pop_log.delete();
        out_ready = 1'b1;
        send(2'd0, 1, 1, 1'b0, 2'd2, 2, 0, 0);
        send(2'd0, 1, 1, 1'b0, 2'd3, 2, 0, 0);
        in_valid = 1'b0;
        wait_drain();
        chk("stall_count", pop_log.size(), 4);
        if (pop_log.size() == 4) chk("stall_no_gaps", pop_log[3] - pop_log[0], 3);

        // Reset with two ops in flight: everything discarded at once.
        send(2'd0, 10, 10, 1'b0, 2'd1, 20, 0, 0);
        send(2'd0, 20, 20, 1'b0, 2'd2, 40, 0, 0);
        in_valid = 1'b0;
        chk("pre_rst_out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_result", out_result, 0);
        chk("async_rst_tag", out_tag, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_release_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_out_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(2'd1, 0, 1, 1'b0, 2'd0, 59, 1, 0);
        in_valid = 1'b0;
        wait_drain();

        // Random stream under random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [1:0] op;
                    int a;
                    int b;
                    logic cin;
                    exp_t e;
                    op  = 2'($urandom_range(0, 3));
                    a   = $urandom_range(0, 63);
                    b   = $urandom_range(0, 63);
                    cin = 1'($urandom_range(0, 1));
                    e   = model(op, a, b, cin, 2'(i));
                    send(op, a, b, cin, 2'(i), e.res, e.cout, e.err);
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("scoreboard_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
